// File: rtl/stage7_ctrl_pkg.sv
// Shared encodings for the multicycle control unit.
// State codes, opcodes and datapath select values.
package stage7_ctrl_pkg;

  typedef enum logic [4:0] {
    S_FETCH    = 5'd0,
    S_DECODE   = 5'd1,
    S_MEMADDR  = 5'd2,
    S_MEMREAD  = 5'd3,
    S_MEMWB    = 5'd4,
    S_MEMWRITE = 5'd5,
    S_EXEC_R   = 5'd6,
    S_RWB      = 5'd7,
    S_EXEC_I   = 5'd8,
    S_IWB      = 5'd9,
    S_BRANCH   = 5'd10,
    S_JUMP     = 5'd11,
    S_JAL      = 5'd12,
    S_JR       = 5'd13,
    S_HALT     = 5'd14
  } state_t;

  localparam logic [3:0] OP_R    = 4'h0;
  localparam logic [3:0] OP_I    = 4'h1;
  localparam logic [3:0] OP_LW   = 4'h2;
  localparam logic [3:0] OP_SW   = 4'h3;
  localparam logic [3:0] OP_BEQ  = 4'h4;
  localparam logic [3:0] OP_BNE  = 4'h5;
  localparam logic [3:0] OP_J    = 4'h6;
  localparam logic [3:0] OP_JAL  = 4'h7;
  localparam logic [3:0] OP_JR   = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_FUNC = 2'b10;

  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_TWO = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;
  localparam logic [1:0] SRCB_OFF = 2'b11;

  localparam logic [1:0] PCS_ALU = 2'b00;
  localparam logic [1:0] PCS_OUT = 2'b01;
  localparam logic [1:0] PCS_JMP = 2'b10;
  localparam logic [1:0] PCS_REG = 2'b11;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MEM = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;

endpackage

// File: rtl/stage7_control_unit.sv
// Multicycle control FSM: state register, next-state
// logic and a combinational output decoder.
module stage7_control_unit
  import stage7_ctrl_pkg::*;
(
  input  logic       CLK,
  input  logic       CtrlRst_n,
  input  logic [3:0] Opcode,
  input  logic       Zero,
  input  logic       MemAck,
  output logic       MemReq,
  output logic       MemWrite,
  output logic       IorD,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       PCWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [1:0] MemToReg,
  output logic [4:0] CurrentState,
  output logic [4:0] NextState,
  output logic       Halted
);

  state_t     state_q, state_d;
  logic [3:0] op_q, op_d;

  logic mem_req_c, mem_wr_c, ir_wr_c;
  logic reg_wr_c, pc_wr_c, halted_c;

  always_ff @(posedge CLK or negedge CtrlRst_n) begin
    if (!CtrlRst_n) begin
      state_q <= S_FETCH;
      op_q    <= 4'h0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    op_d    = op_q;
    unique case (state_q)
      S_FETCH:
        state_d = MemAck ? S_DECODE : S_FETCH;
      S_DECODE: begin
        op_d = Opcode;
        case (Opcode)
          OP_R:            state_d = S_EXEC_R;
          OP_I:            state_d = S_EXEC_I;
          OP_LW, OP_SW:    state_d = S_MEMADDR;
          OP_BEQ, OP_BNE:  state_d = S_BRANCH;
          OP_J:            state_d = S_JUMP;
          OP_JAL:          state_d = S_JAL;
          OP_JR:           state_d = S_JR;
          OP_HALT:         state_d = S_HALT;
          default:         state_d = S_FETCH;
        endcase
      end
      S_MEMADDR:
        state_d = (op_q == OP_SW) ? S_MEMWRITE
                                  : S_MEMREAD;
      S_MEMREAD:
        state_d = MemAck ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE:
        state_d = MemAck ? S_FETCH : S_MEMWRITE;
      S_EXEC_R: state_d = S_RWB;
      S_EXEC_I: state_d = S_IWB;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    mem_req_c = 1'b0;
    mem_wr_c  = 1'b0;
    IorD      = 1'b0;
    ir_wr_c   = 1'b0;
    reg_wr_c  = 1'b0;
    pc_wr_c   = 1'b0;
    halted_c  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_REG;
    ALUOp     = ALU_ADD;
    PCSource  = PCS_ALU;
    MemToReg  = M2R_ALU;
    unique case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        ALUSrcB   = SRCB_TWO;
        ir_wr_c   = MemAck;
        pc_wr_c   = MemAck;
      end
      S_DECODE:
        ALUSrcB = SRCB_OFF;
      S_MEMADDR, S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: begin
        mem_req_c = 1'b1;
        IorD      = 1'b1;
      end
      S_MEMWB: begin
        reg_wr_c = 1'b1;
        MemToReg = M2R_MEM;
      end
      S_MEMWRITE: begin
        mem_req_c = 1'b1;
        mem_wr_c  = 1'b1;
        IorD      = 1'b1;
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_FUNC;
      end
      S_RWB, S_IWB:
        reg_wr_c = 1'b1;
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = ALU_SUB;
        PCSource = PCS_OUT;
        pc_wr_c  = ((op_q == OP_BEQ) &  Zero) |
                   ((op_q == OP_BNE) & ~Zero);
      end
      S_JUMP: begin
        pc_wr_c  = 1'b1;
        PCSource = PCS_JMP;
      end
      S_JAL: begin
        pc_wr_c  = 1'b1;
        reg_wr_c = 1'b1;
        PCSource = PCS_JMP;
        MemToReg = M2R_PC;
      end
      S_JR: begin
        pc_wr_c  = 1'b1;
        PCSource = PCS_REG;
      end
      S_HALT:
        halted_c = 1'b1;
      default: ;
    endcase
  end

  // Reset is applied combinationally so enables drop with rst_n itself.
  assign MemReq       = mem_req_c & CtrlRst_n;
  assign MemWrite     = mem_wr_c  & CtrlRst_n;
  assign IRWrite      = ir_wr_c   & CtrlRst_n;
  assign RegWrite     = reg_wr_c  & CtrlRst_n;
  assign PCWrite      = pc_wr_c   & CtrlRst_n;
  assign Halted       = halted_c  & CtrlRst_n;
  assign CurrentState = state_q;
  assign NextState    = CtrlRst_n ? state_d : S_FETCH;

endmodule

// File: tb/tb_stage7_control_unit.sv
// Directed bench for the multicycle control unit.
// Expectations are queued per cycle and checked mid-cycle.
module tb_stage7_control_unit;

  logic       CLK = 1'b0;
  logic       CtrlRst_n;
  logic [3:0] Opcode;
  logic       Zero;
  logic       MemAck;
  logic       MemReq, MemWrite, IorD;
  logic       IRWrite, RegWrite, PCWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource, MemToReg;
  logic [4:0] CurrentState, NextState;
  logic       Halted;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string      tag;
    logic [4:0] st;
    logic [4:0] nx;
    logic [6:0] vec;
    logic [8:0] sel;
  } exp_t;

  exp_t sb[$];

  // {MemReq,MemWrite,IorD,IRWrite,RegWrite,PCWrite,Halted}
  localparam logic [6:0] V_NONE  = 7'b0000000;
  localparam logic [6:0] V_FWAIT = 7'b1000000;
  localparam logic [6:0] V_FACK  = 7'b1001010;
  localparam logic [6:0] V_RD    = 7'b1010000;
  localparam logic [6:0] V_WR    = 7'b1110000;
  localparam logic [6:0] V_RW    = 7'b0000100;
  localparam logic [6:0] V_PC    = 7'b0000010;
  localparam logic [6:0] V_JAL   = 7'b0000110;
  localparam logic [6:0] V_HALT  = 7'b0000001;

  // {ALUSrcA,ALUSrcB,ALUOp,PCSource,MemToReg}
  localparam logic [8:0] X_NONE = 9'b0_00_00_00_00;
  localparam logic [8:0] X_FET  = 9'b0_01_00_00_00;
  localparam logic [8:0] X_DEC  = 9'b0_11_00_00_00;
  localparam logic [8:0] X_IMM  = 9'b1_10_00_00_00;
  localparam logic [8:0] X_MWB  = 9'b0_00_00_00_01;
  localparam logic [8:0] X_EXR  = 9'b1_00_10_00_00;
  localparam logic [8:0] X_BR   = 9'b1_00_01_01_00;
  localparam logic [8:0] X_J    = 9'b0_00_00_10_00;
  localparam logic [8:0] X_JAL  = 9'b0_00_00_10_10;
  localparam logic [8:0] X_JR   = 9'b0_00_00_11_00;

  stage7_control_unit dut (
    .CLK          (CLK),
    .CtrlRst_n    (CtrlRst_n),
    .Opcode       (Opcode),
    .Zero         (Zero),
    .MemAck       (MemAck),
    .MemReq       (MemReq),
    .MemWrite     (MemWrite),
    .IorD         (IorD),
    .IRWrite      (IRWrite),
    .RegWrite     (RegWrite),
    .PCWrite      (PCWrite),
    .ALUSrcA      (ALUSrcA),
    .ALUSrcB      (ALUSrcB),
    .ALUOp        (ALUOp),
    .PCSource     (PCSource),
    .MemToReg     (MemToReg),
    .CurrentState (CurrentState),
    .NextState    (NextState),
    .Halted       (Halted)
  );

  always #5 CLK = ~CLK;

  task automatic check_now();
    exp_t e;
    logic [6:0] v;
    logic [8:0] s;
    e = sb.pop_front();
    v = {MemReq, MemWrite, IorD, IRWrite,
         RegWrite, PCWrite, Halted};
    s = {ALUSrcA, ALUSrcB, ALUOp, PCSource, MemToReg};
    n_assert++;
    assert (CurrentState === e.st) else begin
      n_fail++;
      $error("FAIL %s state got %0d exp %0d",
             e.tag, CurrentState, e.st);
    end
    n_assert++;
    assert (NextState === e.nx) else begin
      n_fail++;
      $error("FAIL %s next got %0d exp %0d",
             e.tag, NextState, e.nx);
    end
    n_assert++;
    assert (v === e.vec) else begin
      n_fail++;
      $error("FAIL %s enables got %b exp %b",
             e.tag, v, e.vec);
    end
    n_assert++;
    assert (s === e.sel) else begin
      n_fail++;
      $error("FAIL %s selects got %b exp %b",
             e.tag, s, e.sel);
    end
  endtask

  // Called just after a rising edge with inputs already driven.
  task automatic cyc(input string tag, input logic [4:0] st,
                     input logic [4:0] nx, input logic [6:0] vec,
                     input logic [8:0] sel);
    exp_t e;
    e.tag = tag; e.st = st; e.nx = nx;
    e.vec = vec; e.sel = sel;
    sb.push_back(e);
    @(negedge CLK);
    check_now();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    CtrlRst_n = 1'b0;
    Opcode    = 4'h0;
    Zero      = 1'b0;
    MemAck    = 1'b1;
    @(posedge CLK); #1;
    cyc("rst", 0, 0, V_NONE, X_FET);

    CtrlRst_n = 1'b1;
    cyc("r_fetch", 0, 1, V_FACK, X_FET);
    cyc("r_dec",   1, 6, V_NONE, X_DEC);
    Opcode = 4'h3;
    cyc("r_exec",  6, 7, V_NONE, X_EXR);
    cyc("r_rwb",   7, 0, V_RW,   X_NONE);

    MemAck = 1'b0;
    for (int i = 0; i < 3; i++)
      cyc("fwait", 0, 0, V_FWAIT, X_FET);
    MemAck = 1'b1;
    Opcode = 4'h1;
    cyc("fack",    0, 1, V_FACK, X_FET);
    cyc("i_dec",   1, 8, V_NONE, X_DEC);
    cyc("i_exec",  8, 9, V_NONE, X_IMM);
    cyc("i_iwb",   9, 0, V_RW,   X_NONE);

    Opcode = 4'h2;
    cyc("lw_fetch", 0, 1, V_FACK, X_FET);
    cyc("lw_dec",   1, 2, V_NONE, X_DEC);
    Opcode = 4'h3;
    cyc("lw_addr",  2, 3, V_NONE, X_IMM);
    MemAck = 1'b0;
    cyc("lw_wait",  3, 3, V_RD,   X_NONE);
    MemAck = 1'b1;
    cyc("lw_read",  3, 4, V_RD,   X_NONE);
    cyc("lw_wb",    4, 0, V_RW,   X_MWB);

    cyc("sw_fetch", 0, 1, V_FACK, X_FET);
    cyc("sw_dec",   1, 2, V_NONE, X_DEC);
    Opcode = 4'h2;
    cyc("sw_addr",  2, 5, V_NONE, X_IMM);
    cyc("sw_write", 5, 0, V_WR,   X_NONE);

    Opcode = 4'h4; Zero = 1'b1;
    cyc("beq_fetch", 0, 1,  V_FACK, X_FET);
    cyc("beq_dec",   1, 10, V_NONE, X_DEC);
    cyc("beq_z1",    10, 0, V_PC,   X_BR);
    Opcode = 4'h5;
    cyc("bne_fetch", 0, 1,  V_FACK, X_FET);
    cyc("bne_dec",   1, 10, V_NONE, X_DEC);
    cyc("bne_z1",    10, 0, V_NONE, X_BR);
    Zero = 1'b0;
    cyc("bne_fetch2", 0, 1,  V_FACK, X_FET);
    cyc("bne_dec2",   1, 10, V_NONE, X_DEC);
    cyc("bne_z0",     10, 0, V_PC,   X_BR);

    Opcode = 4'h6;
    cyc("j_fetch",   0, 1,  V_FACK, X_FET);
    cyc("j_dec",     1, 11, V_NONE, X_DEC);
    cyc("j_exec",    11, 0, V_PC,   X_J);
    Opcode = 4'h7;
    cyc("jal_fetch", 0, 1,  V_FACK, X_FET);
    cyc("jal_dec",   1, 12, V_NONE, X_DEC);
    cyc("jal_exec",  12, 0, V_JAL,  X_JAL);
    Opcode = 4'h8;
    cyc("jr_fetch",  0, 1,  V_FACK, X_FET);
    cyc("jr_dec",    1, 13, V_NONE, X_DEC);
    cyc("jr_exec",   13, 0, V_PC,   X_JR);

    Opcode = 4'hA;
    cyc("ill_fetch", 0, 1, V_FACK, X_FET);
    cyc("ill_dec",   1, 0, V_NONE, X_DEC);
    cyc("ill_back",  0, 1, V_FACK, X_FET);

    Opcode = 4'hF;
    cyc("h_dec", 1, 14, V_NONE, X_DEC);
    for (int i = 0; i < 10; i++) begin
      MemAck = i[0];
      Opcode = 4'(i);
      cyc("halt", 14, 14, V_HALT, X_NONE);
    end
    CtrlRst_n = 1'b0;
    cyc("h_rst", 0, 0, V_NONE, X_FET);
    CtrlRst_n = 1'b1;
    MemAck = 1'b1;
    Opcode = 4'h2;
    cyc("h_fetch", 0, 1, V_FACK, X_FET);

    cyc("ar_dec",  1, 2, V_NONE, X_DEC);
    cyc("ar_addr", 2, 3, V_NONE, X_IMM);
    MemAck = 1'b0;
    cyc("ar_wait", 3, 3, V_RD,   X_NONE);
    #2;
    CtrlRst_n = 1'b0;
    cyc("ar_async", 0, 0, V_NONE, X_FET);
    CtrlRst_n = 1'b1;
    MemAck = 1'b1;
    Opcode = 4'h0;
    cyc("ar_fetch", 0, 1, V_FACK, X_FET);
    cyc("ar_dec2",  1, 6, V_NONE, X_DEC);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
